uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Fills the currently stubbed receive path (rx_rdy / rx_data) in the UART top.
- Samples the serial rx line using the 16x oversample enable rx_bd_en from baud_rate_en, with majority vote at mid-bit.
- Frame: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit. Byte delivered through a ready/ack hold register.

---
 rtl/uart_rx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with majority-vote bit decisions
// and a ready/ack hold register. Frame: start, 8 data bits LSB first,
// optional parity bit, one stop bit.
module uart_rx #(
  parameter string PARITY = "ODD"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bd_en,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       rx_ack,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_ovr
);

  localparam bit HAS_PARITY = (PARITY != "NONE");
  // Expected XOR over data plus parity bit: 1 for odd parity, 0 for even.
  localparam bit PAR_EXPECT = (PARITY == "ODD");

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Synchronizer and edge-detect history.
  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q,    rx_s_d;
  logic       rx_prev_q, rx_prev_d;

  // Framing state.
  state_t     state_q,   state_d;
  logic [3:0] tcnt_q,    tcnt_d;
  logic [2:0] bcnt_q,    bcnt_d;
  logic       samp7_q,   samp7_d;
  logic       samp8_q,   samp8_d;
  logic [7:0] shift_q,   shift_d;
  logic       perr_frame_q, perr_frame_d;

  // Hold register seen by the consumer.
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_rdy_q,  rx_rdy_d;
  logic       rx_perr_q, rx_perr_d;
  logic       rx_ferr_q, rx_ferr_d;
  logic       rx_ovr_q,  rx_ovr_d;

  logic       majority;
  logic       decide;
  logic       wrap;
  logic       falling;
  logic       deliver;
  logic       frame_err;

  // Two-flop synchronizer plus one more flop for falling-edge detection.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
  end

  // Shared decision terms: the third sample is the live value at tcnt 9.
  always_comb begin
    majority = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);
    decide   = rx_bd_en && (tcnt_q == 4'd9);
    wrap     = rx_bd_en && (tcnt_q == 4'd15);
    falling  = rx_prev_q && !rx_s_q;
  end

  // Next-state logic for the framing FSM, tick counter and shift register.
  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    samp7_d      = samp7_q;
    samp8_d      = samp8_q;
    shift_d      = shift_q;
    perr_frame_d = perr_frame_q;
    deliver      = 1'b0;
    frame_err    = 1'b0;

    if ((state_q == ST_START || state_q == ST_DATA ||
         state_q == ST_PARITY || state_q == ST_STOP) && rx_bd_en) begin
      tcnt_d = tcnt_q + 4'd1;
      if (tcnt_q == 4'd7) samp7_d = rx_s_q;
      if (tcnt_q == 4'd8) samp8_d = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (falling) begin
          tcnt_d       = 4'd0;
          perr_frame_d = 1'b0;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        if (decide && majority) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          bcnt_d  = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide) shift_d[bcnt_q] = majority;
        if (wrap) begin
          if (bcnt_q == 3'd7) begin
            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (decide) perr_frame_d = ((^shift_q) ^ majority) != PAR_EXPECT;
        if (wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave on the decision rather than the wrap so a start edge that
        // follows immediately is not missed.
        if (decide) begin
          if (majority) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold register and handshake: a delivery either loads (slot free or
  // being acked this clk) or is dropped as an overrun.
  always_comb begin
    rx_data_d = rx_data_q;
    rx_rdy_d  = rx_rdy_q;
    rx_perr_d = rx_perr_q;
    rx_ovr_d  = rx_ovr_q;
    rx_ferr_d = frame_err;

    if (deliver && (!rx_rdy_q || rx_ack)) begin
      rx_data_d = shift_q;
      rx_perr_d = perr_frame_q;
      rx_rdy_d  = 1'b1;
      rx_ovr_d  = 1'b0;
    end else if (deliver) begin
      rx_ovr_d  = 1'b1;
    end else if (rx_rdy_q && rx_ack) begin
      rx_rdy_d  = 1'b0;
      rx_ovr_d  = 1'b0;
    end
  end

  // State registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= ST_IDLE;
      tcnt_q       <= 4'd0;
      bcnt_q       <= 3'd0;
      samp7_q      <= 1'b0;
      samp8_q      <= 1'b0;
      shift_q      <= 8'd0;
      perr_frame_q <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_rdy_q     <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_ovr_q     <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      samp7_q      <= samp7_d;
      samp8_q      <= samp8_d;
      shift_q      <= shift_d;
      perr_frame_q <= perr_frame_d;
      rx_data_q    <= rx_data_d;
      rx_rdy_q     <= rx_rdy_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_ovr_q     <= rx_ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_perr = rx_perr_q;
  assign rx_ferr = rx_ferr_q;
  assign rx_ovr  = rx_ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into an odd-parity and an even-parity
// receiver, with tick-aligned glitches and ack timing.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bdEn = 1'b0;
   logic       rxLine = 1'b1;
   logic       useEven = 1'b0;
   logic       ackOdd = 1'b0;
   logic       ackEven = 1'b0;
   logic       rxOdd;
   logic       rxEven;

   logic [7:0] dataOdd;
   logic       rdyOdd;
   logic       perrOdd;
   logic       ferrOdd;
   logic       ovrOdd;
   logic [7:0] dataEven;
   logic       rdyEven;
   logic       perrEven;
   logic       ferrEven;
   logic       ovrEven;

   int         testCount = 0;
   int         failCount = 0;
   int         ferrOddCount = 0;
   int         ferrBase;

   assign rxOdd  = useEven ? 1'b1 : rxLine;
   assign rxEven = useEven ? rxLine : 1'b1;

   uart_rx #(.PARITY("ODD")) dutOdd (
      .clk      (clk),
      .rst      (rst),
      .rx_bd_en (bdEn),
      .rx       (rxOdd),
      .rx_data  (dataOdd),
      .rx_rdy   (rdyOdd),
      .rx_ack   (ackOdd),
      .rx_perr  (perrOdd),
      .rx_ferr  (ferrOdd),
      .rx_ovr   (ovrOdd)
   );

   uart_rx #(.PARITY("EVEN")) dutEven (
      .clk      (clk),
      .rst      (rst),
      .rx_bd_en (bdEn),
      .rx       (rxEven),
      .rx_data  (dataEven),
      .rx_rdy   (rdyEven),
      .rx_ack   (ackEven),
      .rx_perr  (perrEven),
      .rx_ferr  (ferrEven),
      .rx_ovr   (ovrEven)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   // 16x tick: one clk high out of every four, changed on the falling edge
   initial begin
      forever begin
         repeat (3) @(negedge clk);
         bdEn = 1'b1;
         @(negedge clk);
         bdEn = 1'b0;
      end
   end

   // Count clks with the frame-error pulse high, so a one-clk pulse adds one
   always @(negedge clk) begin
      if (ferrOdd) ferrOddCount++;
   end

   function automatic logic oddPar(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One 11-bit frame, 64 clks per bit, aligned just after a tick. glitchBit
   // selects a bit that gets a one-clk low at the clk the receiver samples
   // for tcnt 8; ackOnStop raises ackOdd on the stop-bit delivery clk.
   task automatic applyStimulus(input logic [7:0] data, input logic parBit,
                                input logic stopBit, input int glitchBit,
                                input logic ackOnStop);
      logic [10:0] bits;
      bits = {stopBit, parBit, data, 1'b0};
      do @(posedge clk); while (!bdEn);
      @(negedge clk);
      for (int n = 0; n < 11; n++) begin
         for (int c = 0; c < 64; c++) begin
            rxLine = (n == glitchBit && c == 33) ? 1'b0 : bits[n];
            if (ackOnStop) ackOdd = (n == 10 && c == 39);
            @(negedge clk);
         end
      end
      rxLine = 1'b1;
   endtask

   task automatic pulseAckOdd();
      ackOdd = 1'b1;
      @(negedge clk);
      ackOdd = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset data", 32'(dataOdd), 32'h0);
      checkOutput("reset rdy", 32'(rdyOdd), 32'h0);
      checkOutput("reset perr", 32'(perrOdd), 32'h0);
      checkOutput("reset ferr", 32'(ferrOdd), 32'h0);
      checkOutput("reset ovr", 32'(ovrOdd), 32'h0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      applyStimulus(8'hA5, 1'b1, 1'b1, -1, 1'b0);
      checkOutput("A5 rdy", 32'(rdyOdd), 32'h1);
      checkOutput("A5 data", 32'(dataOdd), 32'hA5);
      checkOutput("A5 perr", 32'(perrOdd), 32'h0);
      pulseAckOdd();
      checkOutput("A5 ack clears rdy", 32'(rdyOdd), 32'h0);

      applyStimulus(8'hA5, 1'b0, 1'b1, -1, 1'b0);
      checkOutput("A5 badpar rdy", 32'(rdyOdd), 32'h1);
      checkOutput("A5 badpar data", 32'(dataOdd), 32'hA5);
      checkOutput("A5 badpar perr", 32'(perrOdd), 32'h1);
      pulseAckOdd();

      useEven = 1'b1;
      applyStimulus(8'h03, 1'b0, 1'b1, -1, 1'b0);
      useEven = 1'b0;
      checkOutput("even 03 rdy", 32'(rdyEven), 32'h1);
      checkOutput("even 03 data", 32'(dataEven), 32'h03);
      checkOutput("even 03 perr", 32'(perrEven), 32'h0);
      checkOutput("odd idle during even", 32'(rdyOdd), 32'h0);
      ackEven = 1'b1;
      @(negedge clk);
      ackEven = 1'b0;

      ferrBase = ferrOddCount;
      applyStimulus(8'h3C, oddPar(8'h3C), 1'b0, -1, 1'b0);
      repeat (20) @(negedge clk);
      checkOutput("3C ferr pulses", 32'(ferrOddCount - ferrBase), 32'd1);
      checkOutput("3C no rdy", 32'(rdyOdd), 32'h0);
      applyStimulus(8'h55, oddPar(8'h55), 1'b1, -1, 1'b0);
      checkOutput("55 rdy", 32'(rdyOdd), 32'h1);
      checkOutput("55 data", 32'(dataOdd), 32'h55);
      checkOutput("55 perr", 32'(perrOdd), 32'h0);
      checkOutput("55 no extra ferr", 32'(ferrOddCount - ferrBase), 32'd1);
      pulseAckOdd();

      ferrBase = ferrOddCount;
      rxLine = 1'b0;
      repeat (16) @(negedge clk);
      rxLine = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("idle glitch rdy", 32'(rdyOdd), 32'h0);
      checkOutput("idle glitch ferr", 32'(ferrOddCount - ferrBase), 32'd0);
      applyStimulus(8'hFF, oddPar(8'hFF), 1'b1, 1, 1'b0);
      checkOutput("FF glitch rdy", 32'(rdyOdd), 32'h1);
      checkOutput("FF glitch data", 32'(dataOdd), 32'hFF);
      pulseAckOdd();

      applyStimulus(8'h11, oddPar(8'h11), 1'b1, -1, 1'b0);
      applyStimulus(8'h22, oddPar(8'h22), 1'b1, -1, 1'b0);
      checkOutput("ovr data kept", 32'(dataOdd), 32'h11);
      checkOutput("ovr rdy", 32'(rdyOdd), 32'h1);
      checkOutput("ovr flag", 32'(ovrOdd), 32'h1);
      pulseAckOdd();
      checkOutput("ovr ack rdy", 32'(rdyOdd), 32'h0);
      checkOutput("ovr ack flag", 32'(ovrOdd), 32'h0);

      applyStimulus(8'h11, oddPar(8'h11), 1'b1, -1, 1'b0);
      applyStimulus(8'h22, oddPar(8'h22), 1'b1, -1, 1'b1);
      checkOutput("simul ack data", 32'(dataOdd), 32'h22);
      checkOutput("simul ack rdy", 32'(rdyOdd), 32'h1);
      checkOutput("simul ack ovr", 32'(ovrOdd), 32'h0);

      applyStimulus(8'h44, oddPar(8'h44), 1'b1, -1, 1'b0);
      checkOutput("pre-reset ovr", 32'(ovrOdd), 32'h1);
      checkOutput("pre-reset data", 32'(dataOdd), 32'h22);

      rxLine = 1'b0;
      repeat (148) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midframe reset data", 32'(dataOdd), 32'h0);
      checkOutput("midframe reset rdy", 32'(rdyOdd), 32'h0);
      checkOutput("midframe reset perr", 32'(perrOdd), 32'h0);
      checkOutput("midframe reset ferr", 32'(ferrOdd), 32'h0);
      checkOutput("midframe reset ovr", 32'(ovrOdd), 32'h0);
      rxLine = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (800) @(negedge clk);
      checkOutput("no partial byte", 32'(rdyOdd), 32'h0);
      applyStimulus(8'h7E, oddPar(8'h7E), 1'b1, -1, 1'b0);
      checkOutput("7E rdy", 32'(rdyOdd), 32'h1);
      checkOutput("7E data", 32'(dataOdd), 32'h7E);
      checkOutput("7E perr", 32'(perrOdd), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
